// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_ctrl
// Brief    : Valid/ready sequencing controller for a signed ALU with
//            single-cycle add/sub/move/swap and iterative mul/div.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       functCode,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] remainder,
    output logic             o,
    output logic             dz,
    output logic             illegal,
    output logic             busy
);

    localparam int             CW         = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  C_CNT_LAST = CW'(WIDTH);
    localparam logic [3:0]     C_OP_ADD   = 4'b0000;
    localparam logic [3:0]     C_OP_SUB   = 4'b0001;
    localparam logic [3:0]     C_OP_MUL   = 4'b0100;
    localparam logic [3:0]     C_OP_DIV   = 4'b0101;
    localparam logic [3:0]     C_OP_MOVE  = 4'b0111;
    localparam logic [3:0]     C_OP_SWAP  = 4'b1000;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_EXEC = 3'd1,
        S_MUL  = 3'd2,
        S_DIV  = 3'd3,
        S_FIX  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;

    logic [3:0]             r_func;
    logic [WIDTH-1:0]       r_op1;
    logic [WIDTH-1:0]       r_op2;
    logic                   r_neg;
    logic [CW-1:0]          r_cnt;

    logic [2*WIDTH-1:0]     r_acc;
    logic [2*WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]       r_mplier;

    logic [WIDTH-1:0]       r_quo;
    logic [WIDTH-1:0]       r_rem;
    logic [WIDTH-1:0]       r_dvsr;

    logic [WIDTH-1:0]       r_result;
    logic [WIDTH-1:0]       r_remainder;
    logic                   r_o;
    logic                   r_dz;
    logic                   r_illegal;

    logic [WIDTH-1:0]       w_mag1;
    logic [WIDTH-1:0]       w_mag2;
    logic [WIDTH-1:0]       w_sum;
    logic [WIDTH-1:0]       w_diff;
    logic [2*WIDTH-1:0]     w_prod;
    logic                   w_mul_ovf;
    logic [WIDTH:0]         w_rem_sh;
    logic [WIDTH:0]         w_trial;
    logic                   w_div_ovf;

    // Operand magnitudes; the most negative value maps to 2^(WIDTH-1) unsigned.
    assign w_mag1    = op1[WIDTH-1] ? (~op1 + 1'b1) : op1;
    assign w_mag2    = op2[WIDTH-1] ? (~op2 + 1'b1) : op2;

    assign w_sum     = r_op1 + r_op2;
    assign w_diff    = r_op1 - r_op2;

    assign w_prod    = r_neg ? (~r_acc + 1'b1) : r_acc;
    assign w_mul_ovf = (w_prod[2*WIDTH-1:WIDTH] != {WIDTH{w_prod[WIDTH-1]}});

    assign w_rem_sh  = {r_rem, r_quo[WIDTH-1]};
    assign w_trial   = w_rem_sh - {1'b0, r_dvsr};
    assign w_div_ovf = (r_op1 == {1'b1, {(WIDTH-1){1'b0}}}) && (r_op2 == {WIDTH{1'b1}});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    if (functCode == C_OP_MUL) begin
                        w_next_state = S_MUL;
                    end else if ((functCode == C_OP_DIV) && (op2 != '0)) begin
                        w_next_state = S_DIV;
                    end else begin
                        w_next_state = S_EXEC;
                    end
                end
            end
            S_EXEC: w_next_state = S_DONE;
            S_MUL:  if (r_cnt == C_CNT_LAST) w_next_state = S_DONE;
            S_DIV:  if (r_cnt == C_CNT_LAST) w_next_state = S_FIX;
            S_FIX:  w_next_state = S_DONE;
            S_DONE: if (out_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_func      <= '0;
            r_op1       <= '0;
            r_op2       <= '0;
            r_neg       <= 1'b0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_quo       <= '0;
            r_rem       <= '0;
            r_dvsr      <= '0;
            r_result    <= '0;
            r_remainder <= '0;
            r_o         <= 1'b0;
            r_dz        <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_func      <= functCode;
                        r_op1       <= op1;
                        r_op2       <= op2;
                        r_neg       <= op1[WIDTH-1] ^ op2[WIDTH-1];
                        r_cnt       <= '0;
                        r_acc       <= '0;
                        r_mcand     <= {{WIDTH{1'b0}}, w_mag1};
                        r_mplier    <= w_mag2;
                        r_quo       <= w_mag1;
                        r_rem       <= '0;
                        r_dvsr      <= w_mag2;
                        r_result    <= '0;
                        r_remainder <= '0;
                        r_o         <= 1'b0;
                        r_dz        <= 1'b0;
                        r_illegal   <= 1'b0;
                    end
                end
                S_EXEC: begin
                    unique case (r_func)
                        C_OP_ADD: begin
                            r_result <= w_sum;
                            r_o      <= (r_op1[WIDTH-1] == r_op2[WIDTH-1]) &&
                                        (w_sum[WIDTH-1] != r_op1[WIDTH-1]);
                        end
                        C_OP_SUB: begin
                            r_result <= w_diff;
                            r_o      <= (r_op1[WIDTH-1] != r_op2[WIDTH-1]) &&
                                        (w_diff[WIDTH-1] != r_op1[WIDTH-1]);
                        end
                        // Only a zero divisor reaches EXEC with the div opcode.
                        C_OP_DIV: begin
                            r_remainder <= r_op1;
                            r_dz        <= 1'b1;
                        end
                        C_OP_MOVE: begin
                            r_result <= r_op1;
                        end
                        C_OP_SWAP: begin
                            r_result    <= r_op1;
                            r_remainder <= r_op2;
                        end
                        default: begin
                            r_illegal <= 1'b1;
                        end
                    endcase
                end
                S_MUL: begin
                    if (r_cnt == C_CNT_LAST) begin
                        r_result    <= w_prod[WIDTH-1:0];
                        r_remainder <= w_prod[2*WIDTH-1:WIDTH];
                        r_o         <= w_mul_ovf;
                    end else begin
                        if (r_mplier[0]) begin
                            r_acc <= r_acc + r_mcand;
                        end
                        r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
                        r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
                        r_cnt    <= r_cnt + 1'b1;
                    end
                end
                S_DIV: begin
                    if (r_cnt != C_CNT_LAST) begin
                        // Restoring step: keep the trial difference only if non-negative.
                        if (!w_trial[WIDTH]) begin
                            r_rem <= w_trial[WIDTH-1:0];
                            r_quo <= {r_quo[WIDTH-2:0], 1'b1};
                        end else begin
                            r_rem <= w_rem_sh[WIDTH-1:0];
                            r_quo <= {r_quo[WIDTH-2:0], 1'b0};
                        end
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_FIX: begin
                    r_result    <= r_neg ? (~r_quo + 1'b1) : r_quo;
                    r_remainder <= r_op1[WIDTH-1] ? (~r_rem + 1'b1) : r_rem;
                    r_o         <= w_div_ovf;
                end
                S_DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign result    = r_result;
    assign remainder = r_remainder;
    assign o         = r_o;
    assign dz        = r_dz;
    assign illegal   = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq_ctrl
// Brief    : Self-checking bench for alu_seq_ctrl with an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq_ctrl;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   functCode = 4'b0000;
    logic [W-1:0] op1 = '0;
    logic [W-1:0] op2 = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic [W-1:0] remainder;
    logic         o;
    logic         dz;
    logic         illegal;
    logic         busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_seq_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .functCode(functCode), .op1(op1), .op2(op2), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .remainder(remainder),
        .o(o), .dz(dz), .illegal(illegal), .busy(busy)
    );

    // Reference: plain signed integer arithmetic on the operand values.
    function automatic void model(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] res, output logic [W-1:0] rem,
                                  output logic ov, output logic dzz, output logic ill, output int lat);
        longint sa, sb, r, m;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = 0; m = 0;
        res = '0; rem = '0; ov = 1'b0; dzz = 1'b0; ill = 1'b0; lat = 1;
        case (f)
            4'b0000: begin r = sa + sb; res = r[15:0]; ov = (r > 32767) || (r < -32768); end
            4'b0001: begin r = sa - sb; res = r[15:0]; ov = (r > 32767) || (r < -32768); end
            4'b0100: begin
                r = sa * sb; res = r[15:0]; rem = r[31:16];
                ov = (r > 32767) || (r < -32768); lat = 17;
            end
            4'b0101: begin
                if (sb == 0) begin
                    rem = a; dzz = 1'b1;
                end else begin
                    r = sa / sb; m = sa % sb;
                    res = r[15:0]; rem = m[15:0]; ov = (r > 32767); lat = 18;
                end
            end
            4'b0111: res = a;
            4'b1000: begin res = a; rem = b; end
            default: ill = 1'b1;
        endcase
    endfunction

    function automatic logic [W-1:0] rand_opnd();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0: v = 16'h0000;
            1: v = 16'hFFFF;
            2: v = 16'h8000;
            3: v = 16'h7FFF;
            4: v = 16'($urandom_range(0, 15));
            default: v = 16'($urandom);
        endcase
        return v;
    endfunction

    // Presents one command, waits for its response; lat = edges from accept to out_valid.
    task automatic issue(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
        @(negedge clk);
        functCode = f; op1 = a; op2 = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        bit seen;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({in_ready, out_valid, busy, o, dz, illegal} !== 6'b100000) begin errors++;
            $display("FAIL reset_ctrl got=%b exp=100000", {in_ready, out_valid, busy, o, dz, illegal}); end
        checks++; if ({result, remainder} !== 32'h0) begin errors++;
            $display("FAIL reset_data got=%h exp=00000000", {result, remainder}); end
        @(negedge clk); rst = 1'b1;
        // Start a multiply and abort it partway through its iterations.
        @(negedge clk);
        functCode = 4'b0100; op1 = -16'sd300; op2 = 16'sd200; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++;
            $display("FAIL mul_busy got busy=%b in_ready=%b exp busy=1 in_ready=0", busy, in_ready); end
        repeat (4) @(posedge clk);
        #2; rst = 1'b0; #1;
        checks++; if ({in_ready, out_valid, busy, o, dz, illegal} !== 6'b100000 || {result, remainder} !== 32'h0) begin errors++;
            $display("FAIL abort_state got=%b/%h exp=100000/00000000", {in_ready, out_valid, busy, o, dz, illegal}, {result, remainder}); end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++;
            $display("FAIL abort_ready got=%b exp=1", in_ready); end
        seen = 1'b0;
        repeat (20) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin errors++;
            $display("FAIL abort_no_resp got out_valid seen=%b exp=0", seen); end
    endtask

    task automatic test_add_sub();
        int lat;
        issue(4'b0000, 16'sd32767, 16'sd1, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL add_lat got=%0d exp=1", lat); end
        checks++; if (result !== 16'h8000 || o !== 1'b1 || remainder !== 16'h0) begin errors++;
            $display("FAIL add_ovf got res=%h rem=%h o=%b exp res=8000 rem=0000 o=1", result, remainder, o); end
        consume();
        issue(4'b0001, -16'sd5, 16'sd3, lat);
        checks++; if (result !== 16'hFFF8 || o !== 1'b0 || lat !== 1) begin errors++;
            $display("FAIL sub got res=%h o=%b lat=%0d exp res=fff8 o=0 lat=1", result, o, lat); end
        consume();
    endtask

    task automatic test_mul();
        int lat;
        issue(4'b0100, -16'sd300, 16'sd200, lat);
        checks++; if (lat !== 17) begin errors++; $display("FAIL mul_lat got=%0d exp=17", lat); end
        checks++; if ({remainder, result} !== 32'hFFFF15A0 || o !== 1'b1) begin errors++;
            $display("FAIL mul_big got=%h o=%b exp=ffff15a0 o=1", {remainder, result}, o); end
        consume();
        issue(4'b0100, 16'sd7, -16'sd6, lat);
        checks++; if (result !== 16'hFFD6 || remainder !== 16'hFFFF || o !== 1'b0) begin errors++;
            $display("FAIL mul_small got res=%h rem=%h o=%b exp res=ffd6 rem=ffff o=0", result, remainder, o); end
        consume();
    endtask

    task automatic test_div();
        int lat;
        issue(4'b0101, -16'sd7, 16'sd2, lat);
        checks++; if (lat !== 18) begin errors++; $display("FAIL div_lat got=%0d exp=18", lat); end
        checks++; if (result !== 16'hFFFD || remainder !== 16'hFFFF || o !== 1'b0) begin errors++;
            $display("FAIL div_neg got res=%h rem=%h o=%b exp res=fffd rem=ffff o=0", result, remainder, o); end
        consume();
        issue(4'b0101, 16'h8000, 16'hFFFF, lat);
        checks++; if (result !== 16'h8000 || remainder !== 16'h0 || o !== 1'b1) begin errors++;
            $display("FAIL div_ovf got res=%h rem=%h o=%b exp res=8000 rem=0000 o=1", result, remainder, o); end
        consume();
        issue(4'b0101, 16'sd5, 16'sd0, lat);
        checks++; if (lat !== 1 || dz !== 1'b1 || result !== 16'h0 || remainder !== 16'd5 || o !== 1'b0) begin errors++;
            $display("FAIL div_zero got lat=%0d dz=%b res=%h rem=%h o=%b exp lat=1 dz=1 res=0000 rem=0005 o=0", lat, dz, result, remainder, o); end
        consume();
    endtask

    task automatic test_backpressure();
        int lat;
        issue(4'b1000, 16'sd3, 16'sd9, lat);
        // A competing command is offered while the swap response is held.
        @(negedge clk);
        functCode = 4'b0000; op1 = 16'sd100; op2 = 16'sd200; in_valid = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1 || result !== 16'd3 || remainder !== 16'd9 || in_ready !== 1'b0) begin errors++;
                $display("FAIL bp_hold got v=%b res=%h rem=%h rdy=%b exp v=1 res=0003 rem=0009 rdy=0", out_valid, result, remainder, in_ready); end
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++;
            $display("FAIL bp_release got rdy=%b v=%b exp rdy=1 v=0", in_ready, out_valid); end
        @(posedge clk); #1; in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++;
            $display("FAIL bp_accept got rdy=%b exp=0", in_ready); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1 || result !== 16'd300) begin errors++;
            $display("FAIL bp_second got v=%b res=%h exp v=1 res=012c", out_valid, result); end
        consume();
    endtask

    task automatic test_illegal();
        int lat;
        issue(4'b1111, 16'sd11, 16'sd22, lat);
        checks++; if (lat !== 1 || illegal !== 1'b1 || result !== 16'h0 || remainder !== 16'h0) begin errors++;
            $display("FAIL illegal got lat=%0d ill=%b res=%h rem=%h exp lat=1 ill=1 res=0000 rem=0000", lat, illegal, result, remainder); end
        consume();
        issue(4'b0000, 16'sd1, 16'sd2, lat);
        checks++; if (illegal !== 1'b0 || result !== 16'd3) begin errors++;
            $display("FAIL illegal_clear got ill=%b res=%h exp ill=0 res=0003", illegal, result); end
        consume();
    endtask

    task automatic test_back_to_back();
        int lat, e_lat;
        logic [3:0] f;
        logic [W-1:0] a, b, e_res, e_rem;
        logic e_o, e_dz, e_ill;
        logic [3:0] codes [4] = '{4'b0000, 4'b0001, 4'b0111, 4'b1000};
        @(negedge clk); out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            f = codes[$urandom_range(0, 3)]; a = rand_opnd(); b = rand_opnd();
            model(f, a, b, e_res, e_rem, e_o, e_dz, e_ill, e_lat);
            issue(f, a, b, lat);
            checks++; if (lat !== e_lat || result !== e_res || remainder !== e_rem || o !== e_o) begin errors++;
                $display("FAIL b2b f=%b a=%h b=%h got lat=%0d res=%h rem=%h o=%b exp lat=%0d res=%h rem=%h o=%b",
                         f, a, b, lat, result, remainder, o, e_lat, e_res, e_rem, e_o); end
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
                $display("FAIL b2b_turn got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready); end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        int lat, e_lat, hold;
        logic [3:0] f;
        logic [W-1:0] a, b, e_res, e_rem;
        logic e_o, e_dz, e_ill;
        logic [3:0] codes [9] = '{4'b0000, 4'b0001, 4'b0100, 4'b0101, 4'b0111, 4'b1000, 4'b0010, 4'b1111, 4'b0110};
        for (int i = 0; i < 80; i++) begin
            f = codes[$urandom_range(0, 8)]; a = rand_opnd(); b = rand_opnd();
            model(f, a, b, e_res, e_rem, e_o, e_dz, e_ill, e_lat);
            issue(f, a, b, lat);
            checks++; if (lat !== e_lat) begin errors++;
                $display("FAIL rand_lat f=%b a=%h b=%h got=%0d exp=%0d", f, a, b, lat, e_lat); end
            checks++; if (result !== e_res || remainder !== e_rem) begin errors++;
                $display("FAIL rand_data f=%b a=%h b=%h got=%h/%h exp=%h/%h", f, a, b, result, remainder, e_res, e_rem); end
            checks++; if ({o, dz, illegal} !== {e_o, e_dz, e_ill}) begin errors++;
                $display("FAIL rand_flags f=%b a=%h b=%h got=%b exp=%b", f, a, b, {o, dz, illegal}, {e_o, e_dz, e_ill}); end
            hold = $urandom_range(0, 2);
            repeat (hold) begin
                @(posedge clk); #1;
                checks++; if (out_valid !== 1'b1 || result !== e_res || remainder !== e_rem) begin errors++;
                    $display("FAIL rand_hold got v=%b res=%h rem=%h exp v=1 res=%h rem=%h", out_valid, result, remainder, e_res, e_rem); end
            end
            consume();
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_mul();
        test_div();
        test_backpressure();
        test_illegal();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
